// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong design (game logic and render).
package pong_pkg;

  typedef enum logic [2:0] {IDLE, PADDLE, BALL, COLLIDE, COMMIT} state_t;
  typedef enum logic {NEG = 1'b0, POS = 1'b1} dir_t;

  localparam int CORDW_DEF        = 10;
  localparam int H_RES_DEF        = 640;
  localparam int V_RES_DEF        = 480;
  localparam int BALL_SIZE_DEF    = 8;
  localparam int BALL_SPEED_DEF   = 2;
  localparam int PAD_W_DEF        = 8;
  localparam int PAD_H_DEF        = 48;
  localparam int PAD_OFFS_DEF     = 32;
  localparam int PAD_SPEED_DEF    = 2;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int SCOREW_DEF       = 4;

endpackage

// File: rtl/pong_paddle_step.sv
// Combinational paddle mover: one step up or down, clamped to [0, lim_i].
module pong_paddle_step
  import pong_pkg::*;
#(
  parameter int CORDW = CORDW_DEF
) (
  input  logic [CORDW-1:0] pos_i,
  input  logic             mv_i,
  input  dir_t             dir_i,
  input  logic [CORDW-1:0] step_i,
  input  logic [CORDW-1:0] lim_i,
  output logic [CORDW-1:0] pos_o
);

  logic [CORDW:0] sum;

  // One extra bit so a downward step past the limit is still visible.
  assign sum = {1'b0, pos_i} + {1'b0, step_i};

  always_comb begin
    pos_o = pos_i;
    if (mv_i) begin
      if (dir_i == NEG) pos_o = (pos_i < step_i) ? '0 : pos_i - step_i;
      else              pos_o = (sum > {1'b0, lim_i}) ? lim_i : sum[CORDW-1:0];
    end
  end

endmodule

// File: rtl/pong_logic.sv
// Per-frame pong game-state engine: a short fixed sequence on each vblank pulse,
// committing ball, paddle and score outputs together in a single edge.
module pong_logic
  import pong_pkg::*;
#(
  parameter int CORDW        = CORDW_DEF,
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF,
  parameter int BALL_SIZE    = BALL_SIZE_DEF,
  parameter int BALL_SPEED   = BALL_SPEED_DEF,
  parameter int PAD_W        = PAD_W_DEF,
  parameter int PAD_H        = PAD_H_DEF,
  parameter int PAD_OFFS     = PAD_OFFS_DEF,
  parameter int PAD_SPEED    = PAD_SPEED_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int SCOREW       = SCOREW_DEF
) (
  input  logic              pix_clk,
  input  logic              rst_pix,
  input  logic              frame,
  input  logic              btn_up,
  input  logic              btn_dn,
  output logic [CORDW-1:0]  ball_x,
  output logic [CORDW-1:0]  ball_y,
  output logic [CORDW-1:0]  pad_l_y,
  output logic [CORDW-1:0]  pad_r_y,
  output logic [SCOREW-1:0] score_l,
  output logic [SCOREW-1:0] score_r,
  output logic              busy,
  output logic              upd
);

  localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);

  typedef logic signed [CORDW:0] bw_t;

  localparam bw_t BSZ    = bw_t'(BALL_SIZE);
  localparam bw_t BSTEP  = bw_t'(BALL_SPEED);
  localparam bw_t BHALF  = bw_t'(BALL_SIZE / 2);
  localparam bw_t HRES   = bw_t'(H_RES);
  localparam bw_t VRES   = bw_t'(V_RES);
  localparam bw_t X_CTR  = bw_t'((H_RES - BALL_SIZE) / 2);
  localparam bw_t Y_CTR  = bw_t'((V_RES - BALL_SIZE) / 2);
  localparam bw_t Y_MAX  = bw_t'(V_RES - BALL_SIZE);
  localparam bw_t PH     = bw_t'(PAD_H);
  localparam bw_t PHALF  = bw_t'(PAD_H / 2);
  localparam bw_t PL_X   = bw_t'(PAD_OFFS);
  localparam bw_t PL_XR  = bw_t'(PAD_OFFS + PAD_W);
  localparam bw_t PR_X   = bw_t'(H_RES - PAD_OFFS - PAD_W);
  localparam bw_t PR_XR  = bw_t'(H_RES - PAD_OFFS);
  localparam bw_t PR_HIT = bw_t'(H_RES - PAD_OFFS - PAD_W - BALL_SIZE);
  localparam bw_t PSTEP_P = bw_t'(PAD_SPEED);
  localparam bw_t PSTEP_N = bw_t'(-PAD_SPEED);

  localparam logic [CORDW-1:0]   PAD_MAX    = CORDW'(V_RES - PAD_H);
  localparam logic [CORDW-1:0]   PAD_CTR    = CORDW'((V_RES - PAD_H) / 2);
  localparam logic [CORDW-1:0]   PSTEP      = CORDW'(PAD_SPEED);
  localparam logic [SERVE_W-1:0] SERVE_INIT = SERVE_W'(SERVE_FRAMES);

  function automatic logic [SCOREW-1:0] sat_inc(input logic [SCOREW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic ovl(input bw_t y, input logic [CORDW-1:0] pad);
    bw_t p;
    p = $signed({1'b0, pad});
    return (y + BSZ > p) && (y < p + PH);
  endfunction

  // Reset asserts immediately but releases only on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst;

  always_ff @(posedge pix_clk or posedge rst_pix) begin
    if (rst_pix) rst_sync_q <= 2'b11;
    else         rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst = rst_sync_q[1];

  logic up_m_q, up_s_q, dn_m_q, dn_s_q;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      up_m_q <= 1'b0;
      up_s_q <= 1'b0;
      dn_m_q <= 1'b0;
      dn_s_q <= 1'b0;
    end else begin
      up_m_q <= btn_up;
      up_s_q <= up_m_q;
      dn_m_q <= btn_dn;
      dn_s_q <= dn_m_q;
    end
  end

  state_t              state_q, state_d;
  bw_t                 bx_q, bx_d, by_q, by_d;
  dir_t                dx_q, dx_d, dy_q, dy_d;
  logic [CORDW-1:0]    pl_q, pl_d, pr_q, pr_d;
  logic [SCOREW-1:0]   sl_q, sl_d, sr_q, sr_d;
  logic [SERVE_W-1:0]  serve_q, serve_d;
  logic                frz_q, frz_d;
  logic                upd_q, upd_d;

  logic [CORDW-1:0]    pl_step, pr_step;
  logic                l_mv, r_mv;
  dir_t                l_dir, r_dir;
  bw_t                 ball_cy, pad_cy, rdiff;

  assign l_mv  = up_s_q ^ dn_s_q;
  assign l_dir = dn_s_q ? POS : NEG;

  // Right paddle chases the ball centre as it stood before this frame's move.
  assign ball_cy = by_q + BHALF;
  assign pad_cy  = $signed({1'b0, pr_q}) + PHALF;
  assign rdiff   = ball_cy - pad_cy;
  assign r_mv    = (rdiff > PSTEP_P) || (rdiff < PSTEP_N);
  assign r_dir   = rdiff[CORDW] ? NEG : POS;

  pong_paddle_step #(.CORDW(CORDW)) u_step_l (
    .pos_i (pl_q),
    .mv_i  (l_mv),
    .dir_i (l_dir),
    .step_i(PSTEP),
    .lim_i (PAD_MAX),
    .pos_o (pl_step)
  );

  pong_paddle_step #(.CORDW(CORDW)) u_step_r (
    .pos_i (pr_q),
    .mv_i  (r_mv),
    .dir_i (r_dir),
    .step_i(PSTEP),
    .lim_i (PAD_MAX),
    .pos_o (pr_step)
  );

  bw_t  ny;
  dir_t ndy;
  logic hit_l, hit_r;

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    pl_d    = pl_q;
    pr_d    = pr_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    serve_d = serve_q;
    frz_d   = frz_q;
    upd_d   = 1'b0;
    ny      = by_q;
    ndy     = dy_q;
    hit_l   = 1'b0;
    hit_r   = 1'b0;
    case (state_q)
      IDLE: if (frame) state_d = PADDLE;
      PADDLE: begin
        pl_d    = pl_step;
        pr_d    = pr_step;
        state_d = BALL;
      end
      BALL: begin
        if (serve_q != '0) begin
          serve_d = serve_q - 1'b1;
          frz_d   = 1'b1;
        end else begin
          frz_d = 1'b0;
          bx_d  = (dx_q == POS) ? bx_q + BSTEP : bx_q - BSTEP;
          by_d  = (dy_q == POS) ? by_q + BSTEP : by_q - BSTEP;
        end
        state_d = COLLIDE;
      end
      COLLIDE: begin
        if (!frz_q) begin
          if (by_q[CORDW]) begin
            ny  = '0;
            ndy = POS;
          end else if (by_q + BSZ > VRES) begin
            ny  = Y_MAX;
            ndy = NEG;
          end
          by_d  = ny;
          dy_d  = ndy;
          hit_l = (dx_q == NEG) && (bx_q <= PL_XR) && (bx_q + BSZ > PL_X) && ovl(ny, pl_q);
          hit_r = (dx_q == POS) && (bx_q + BSZ >= PR_X) && (bx_q < PR_XR) && ovl(ny, pr_q);
          if (hit_l) begin
            bx_d = PL_XR;
            dx_d = POS;
          end else if (hit_r) begin
            bx_d = PR_HIT;
            dx_d = NEG;
          end else if (bx_q[CORDW] || (bx_q + BSZ > HRES)) begin
            // The ball re-serves toward whoever just conceded.
            if (bx_q[CORDW]) begin
              sr_d = sat_inc(sr_q);
              dx_d = NEG;
            end else begin
              sl_d = sat_inc(sl_q);
              dx_d = POS;
            end
            bx_d    = X_CTR;
            by_d    = Y_CTR;
            serve_d = SERVE_INIT;
          end
        end
        state_d = COMMIT;
      end
      COMMIT: begin
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bx_q    <= X_CTR;
      by_q    <= Y_CTR;
      dx_q    <= POS;
      dy_q    <= POS;
      pl_q    <= PAD_CTR;
      pr_q    <= PAD_CTR;
      sl_q    <= '0;
      sr_q    <= '0;
      serve_q <= SERVE_INIT;
      frz_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      serve_q <= serve_d;
      frz_q   <= frz_d;
      upd_q   <= upd_d;
    end
  end

  // Render-facing registers only change in COMMIT, all on the same edge.
  logic [CORDW-1:0]  ball_x_q, ball_y_q, pad_l_q, pad_r_q;
  logic [SCOREW-1:0] score_l_q, score_r_q;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      ball_x_q  <= X_CTR[CORDW-1:0];
      ball_y_q  <= Y_CTR[CORDW-1:0];
      pad_l_q   <= PAD_CTR;
      pad_r_q   <= PAD_CTR;
      score_l_q <= '0;
      score_r_q <= '0;
    end else if (state_q == COMMIT) begin
      ball_x_q  <= bx_q[CORDW-1:0];
      ball_y_q  <= by_q[CORDW-1:0];
      pad_l_q   <= pl_q;
      pad_r_q   <= pr_q;
      score_l_q <= sl_q;
      score_r_q <= sr_q;
    end
  end

  assign ball_x  = ball_x_q;
  assign ball_y  = ball_y_q;
  assign pad_l_y = pad_l_q;
  assign pad_r_y = pad_r_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign busy    = (state_q != IDLE);
  assign upd     = upd_q;

endmodule

// File: doc/pong_logic.md
Name: pong_logic

Overview:
Per-frame game-state engine for the pong design; sits directly upstream of render and supplies ball and paddle coordinates plus scores.
- Runs on the pixel clock.
- Wakes once per frame on a vblank-start pulse and runs a short fixed-length update sequence.
- Commits all outputs in the same edge, so render never sees a half-updated frame.

Parameters:
CORDW, 10, coordinate width [bits]
H_RES, 640, active width in pixels
V_RES, 480, active height in pixels
BALL_SIZE, 8, ball side length
BALL_SPEED, 2, ball step per frame on each axis
PAD_W, 8, paddle width
PAD_H, 48, paddle height
PAD_OFFS, 32, x of left paddle's left edge; right paddle left edge = H_RES-PAD_OFFS-PAD_W
PAD_SPEED, 2, paddle step per frame
SERVE_FRAMES, 60, frames the ball is frozen after reset or a point
SCOREW, 4, score counter width

Ports:
pix_clk  in  1  pixel clock
rst_pix  in  1  reset, asynchronous, active-high
frame  in  1  one-cycle pulse at vblank start (sy==V_RES, sx==0)
btn_up  in  1  left-player up, asynchronous raw button
btn_dn  in  1  left-player down, asynchronous raw button
ball_x  out  CORDW  ball left edge
ball_y  out  CORDW  ball top edge
pad_l_y  out  CORDW  left paddle top edge
pad_r_y  out  CORDW  right paddle top edge
score_l  out  SCOREW  left score
score_r  out  SCOREW  right score
busy  out  1  update sequence in progress
upd  out  1  one-cycle pulse: new values committed

Behaviour:
- Reset (async assert, sync release via pix_clk):
  - ball_x=(H_RES-BALL_SIZE)/2=316; ball_y=(V_RES-BALL_SIZE)/2=236
  - pad_l_y=pad_r_y=(V_RES-PAD_H)/2=216
  - scores=0; dx=right, dy=down; serve_cnt=SERVE_FRAMES
  - busy=0, upd=0, state=IDLE; synchronizer flops=0
- btn_up/btn_dn: 2-flop synchronizer each, clocked by pix_clk.
- FSM: IDLE -> PADDLE -> BALL -> COLLIDE -> COMMIT -> IDLE, one cycle per state.
  - frame high in IDLE at edge N starts the sequence.
  - Outputs are written and upd=1 at edge N+4.
  - busy = (state != IDLE).
  - frame pulses while busy are ignored and not queued.
- PADDLE: operates on working copies.
  - Left paddle: up&!dn moves -PAD_SPEED, clamped at 0; dn&!up moves +PAD_SPEED, clamped at V_RES-PAD_H; both or neither: hold.
  - Right paddle (AI): compare paddle centre with pre-move ball centre. If |diff| > PAD_SPEED, step PAD_SPEED toward the ball with the same clamps; else hold.
- BALL: if serve_cnt != 0, decrement it and leave the ball unchanged (COLLIDE is a no-op). Otherwise step x by ±BALL_SPEED per dx and y by ±BALL_SPEED per dy.
  - Compute at CORDW+1 bits signed, so underflow below 0 is detectable.
- COLLIDE, in priority order:
  1. Vertical:
     - y<0 -> y=0, dy=down.
     - y+BALL_SIZE>V_RES -> y=V_RES-BALL_SIZE, dy=up.
  2. Paddle hit (uses the new paddle positions); y-overlap means ball_y+BALL_SIZE>pad_y and ball_y<pad_y+PAD_H.
     - Left paddle: dx=left, x<=PAD_OFFS+PAD_W, x+BALL_SIZE>PAD_OFFS, y-overlap -> x=PAD_OFFS+PAD_W, dx=right.
     - Right paddle: mirror -> x=H_RES-PAD_OFFS-PAD_W-BALL_SIZE, dx=left.
  3. Miss:
     - x<0 -> score_r+1.
     - x+BALL_SIZE>H_RES -> score_l+1.
     - On either miss: ball to centre, serve_cnt=SERVE_FRAMES, dx toward the conceding player, dy unchanged.
  - Scores saturate at 2^SCOREW-1.
- COMMIT: copy all working values to the output registers in one edge; pulse upd.
- Reset mid-sequence: immediate return to reset values; no partial commit.

Decomposition:
- pong_pkg:
  - state enum (IDLE, PADDLE, BALL, COLLIDE, COMMIT)
  - direction typedef (dir_t: NEG/POS)
  - default geometry constants, shared with render
- One sub-module, pong_paddle_step: combinational clamped ±step, given position, direction request, speed and limit. Used for both paddles.

Test Plan:
- Reset, then frame pulse: upd exactly 4 cycles after frame; ball stays 316,236 (serve); pads 216; serve_cnt 59.
- After 60 frames, frame 61: ball 318,238 (dx right, dy down); busy high for 4 cycles; frame injected at cycle 2 is ignored.
- btn_up held, pad_l_y=1: next commit 0; held further, stays 0. Both buttons held: no change. Button pulse shorter than 1 cycle handled only via the synchronizer.
- Ball at y=471 moving down: next commit y=472, dy=up; following frame y=470.
- Ball x=41, dx left, pad_l_y overlapping: commit x=40, dx right. Same setup with paddle away: ball travels out, score_r=1, ball recentres to 316,236, 60-frame freeze.
- score_l at 15 plus another right-side miss: stays 15. Assert rst_pix mid-COLLIDE: outputs return to reset values asynchronously; upd never pulses.
